// File: rtl/tick_watchdog_if.sv
// Control/status bundle for tick_watchdog: the controller drives the strobes and
// reload settings; the watchdog returns state, remaining count and event pulses.
interface tick_watchdog_if #(
   parameter int CNT_W = 16
) ();
   logic             tick_1ms;
   logic             enable;
   logic [CNT_W-1:0] timeout;
   logic [CNT_W-1:0] warn_lvl;
   logic             kick;
   logic             clr;
   logic [1:0]       state;
   logic [CNT_W-1:0] remain;
   logic             warn;
   logic             expire_pulse;
   logic             expired;
   logic             kick_err;

   modport master (
      output tick_1ms, enable, timeout, warn_lvl, kick, clr,
      input  state, remain, warn, expire_pulse, expired, kick_err
   );

   modport slave (
      input  tick_1ms, enable, timeout, warn_lvl, kick, clr,
      output state, remain, warn, expire_pulse, expired, kick_err
   );
endinterface

// File: rtl/tick_watchdog.sv
// Millisecond watchdog: counts tick_1ms strobes down from a reloadable timeout, warns, then latches expiry.
// All outputs registered, one-cycle latency; no backpressure, every strobe is acted on the cycle it is sampled.
module tick_watchdog #(
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   tick_watchdog_if.slave  wd
);
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUN     = 2'b01,
      WARN    = 2'b10,
      EXPIRED = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] remain_q, remain_d;
   logic             warn_q, warn_d;
   logic             expire_pulse_q, expire_pulse_d;
   logic             expired_q, expired_d;
   logic             kick_err_q, kick_err_d;
   logic [CNT_W-1:0] load_val;
   logic [CNT_W-1:0] dec_val;

   function automatic state_t classify(input logic [CNT_W-1:0] r,
                                       input logic [CNT_W-1:0] lvl);
      if (r == '0)
         return EXPIRED;
      else if ((lvl != '0) && (r <= lvl))
         return WARN;
      else
         return RUN;
   endfunction

   always_comb begin
      // A zero timeout is treated as one tick so arming never expires on the spot.
      load_val       = (wd.timeout != '0) ? wd.timeout : CNT_W'(1);
      dec_val        = remain_q - CNT_W'(1);
      state_d        = state_q;
      remain_d       = remain_q;
      expire_pulse_d = 1'b0;
      kick_err_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            kick_err_d = wd.kick;
            if (wd.enable) begin
               remain_d = load_val;
               state_d  = classify(load_val, wd.warn_lvl);
            end
         end
         RUN, WARN: begin
            if (!wd.enable) begin
               state_d  = IDLE;
               remain_d = '0;
            end else if (wd.kick) begin
               remain_d = load_val;
               state_d  = classify(load_val, wd.warn_lvl);
            end else if (wd.tick_1ms) begin
               // remain_q is never 0 outside EXPIRED, so this cannot wrap.
               remain_d       = dec_val;
               state_d        = classify(dec_val, wd.warn_lvl);
               expire_pulse_d = (dec_val == '0);
            end
         end
         EXPIRED: begin
            kick_err_d = wd.kick;
            remain_d   = '0;
            if (wd.clr) begin
               if (wd.enable) begin
                  remain_d = load_val;
                  state_d  = classify(load_val, wd.warn_lvl);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d  = IDLE;
            remain_d = '0;
         end
      endcase

      warn_d    = (state_d == WARN);
      expired_d = (state_d == EXPIRED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         remain_q       <= '0;
         warn_q         <= 1'b0;
         expire_pulse_q <= 1'b0;
         expired_q      <= 1'b0;
         kick_err_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         remain_q       <= remain_d;
         warn_q         <= warn_d;
         expire_pulse_q <= expire_pulse_d;
         expired_q      <= expired_d;
         kick_err_q     <= kick_err_d;
      end
   end

   assign wd.state        = state_q;
   assign wd.remain       = remain_q;
   assign wd.warn         = warn_q;
   assign wd.expire_pulse = expire_pulse_q;
   assign wd.expired      = expired_q;
   assign wd.kick_err     = kick_err_q;
endmodule

// File: tb/tb_tick_watchdog.sv
// Bench for tick_watchdog: directed scenarios plus random strobes, every cycle's outputs
// predicted by a tick-counting reference model and compared from a scoreboard queue.
module tb_tick_watchdog;
   localparam int W = 16;

   typedef struct packed {
      logic [1:0]   state;
      logic [W-1:0] remain;
      logic         warn;
      logic         expire_pulse;
      logic         expired;
      logic         kick_err;
   } obs_t;

   logic clk = 1'b0;
   logic rst;
   tick_watchdog_if #(.CNT_W(W)) bus ();

   tick_watchdog #(.CNT_W(W)) dut (
      .clk (clk),
      .rst (rst),
      .wd  (bus)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   obs_t exp_q[$];

   // Reference model: a load fixes L and restarts a tick count; remaining is L minus ticks seen.
   bit m_armed   = 1'b0;
   bit m_expired = 1'b0;
   bit m_warn    = 1'b0;
   int m_len     = 0;
   int m_ticks   = 0;

   function automatic bit in_warn(int r, int lvl);
      return (lvl != 0) && (r <= lvl);
   endfunction

   task automatic model_load(int tmo, int lvl);
      m_armed = 1'b1;
      m_len   = (tmo == 0) ? 1 : tmo;
      m_ticks = 0;
      m_warn  = in_warn(m_len, lvl);
   endtask

   always @(posedge clk) begin
      obs_t e;
      bit   pulse;
      bit   kerr;
      int   tmo;
      int   lvl;
      pulse = 1'b0;
      kerr  = 1'b0;
      tmo   = int'(bus.timeout);
      lvl   = int'(bus.warn_lvl);
      if (rst) begin
         m_armed   = 1'b0;
         m_expired = 1'b0;
         m_warn    = 1'b0;
      end else if (m_expired) begin
         kerr = bus.kick;
         if (bus.clr) begin
            m_expired = 1'b0;
            if (bus.enable) model_load(tmo, lvl);
            else m_armed = 1'b0;
         end
      end else if (!m_armed) begin
         kerr = bus.kick;
         if (bus.enable) model_load(tmo, lvl);
      end else if (!bus.enable) begin
         m_armed = 1'b0;
      end else if (bus.kick) begin
         model_load(tmo, lvl);
      end else if (bus.tick_1ms) begin
         m_ticks++;
         if (m_ticks == m_len) begin
            m_expired = 1'b1;
            pulse     = 1'b1;
         end else begin
            m_warn = in_warn(m_len - m_ticks, lvl);
         end
      end
      e.state        = m_expired ? 2'b11 : (!m_armed ? 2'b00 : (m_warn ? 2'b10 : 2'b01));
      e.remain       = (m_expired || !m_armed) ? '0 : W'(m_len - m_ticks);
      e.warn         = !m_expired && m_armed && m_warn;
      e.expire_pulse = pulse;
      e.expired      = m_expired;
      e.kick_err     = kerr;
      exp_q.push_back(e);
   end

   always @(negedge clk) begin
      obs_t e;
      obs_t a;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a.state        = bus.state;
         a.remain       = bus.remain;
         a.warn         = bus.warn;
         a.expire_pulse = bus.expire_pulse;
         a.expired      = bus.expired;
         a.kick_err     = bus.kick_err;
         checks++;
         if (a !== e) begin
            errors++;
            if (errors <= 20)
               $display("FAIL outputs t=%0t actual st=%b rem=%0d warn=%b pulse=%b exp=%b kerr=%b required st=%b rem=%0d warn=%b pulse=%b exp=%b kerr=%b",
                        $time, a.state, a.remain, a.warn, a.expire_pulse, a.expired, a.kick_err,
                        e.state, e.remain, e.warn, e.expire_pulse, e.expired, e.kick_err);
         end
      end
   end

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         bus.tick_1ms = 1'b0;
         bus.kick     = 1'b0;
         bus.clr      = 1'b0;
         rst          = 1'b0;
      end
   endtask

   task automatic ticks(int count, int gap);
      repeat (count) begin
         bus.tick_1ms = 1'b1;
         step(gap);
      end
   endtask

   task automatic set_cfg(int tmo, int lvl);
      bus.timeout  = W'(tmo);
      bus.warn_lvl = W'(lvl);
   endtask

   initial begin
      rst          = 1'b1;
      bus.tick_1ms = 1'b0;
      bus.enable   = 1'b0;
      bus.kick     = 1'b0;
      bus.clr      = 1'b0;
      set_cfg(0, 0);
      step(2);

      // Arm and expire, then hold in EXPIRED under further ticks.
      set_cfg(5, 0);
      bus.enable = 1'b1;
      step(1);
      ticks(5, 10);
      ticks(10, 10);

      // clr with enable high reloads into a warning-window run, then kick recovery.
      set_cfg(10, 3);
      bus.clr = 1'b1;
      step(1);
      ticks(7, 4);
      bus.kick = 1'b1;
      step(2);
      ticks(10, 3);

      // Kick and tick in the same cycle at remain=1.
      set_cfg(4, 0);
      bus.clr = 1'b1;
      step(1);
      ticks(3, 2);
      bus.kick     = 1'b1;
      bus.tick_1ms = 1'b1;
      step(2);
      ticks(4, 2);

      // Sticky expiry: back-to-back kicks, enable low, clr to IDLE, kick in IDLE.
      bus.kick = 1'b1;
      step(1);
      bus.kick = 1'b1;
      step(1);
      bus.enable = 1'b0;
      step(5);
      bus.clr = 1'b1;
      step(2);
      bus.kick = 1'b1;
      step(2);

      // Boundary: timeout 0 loads 1 and a single tick expires it.
      set_cfg(0, 0);
      bus.enable = 1'b1;
      step(1);
      ticks(1, 3);
      bus.enable = 1'b0;
      bus.clr    = 1'b1;
      step(2);

      // Boundary: warn level above timeout enters WARN on arm.
      set_cfg(3, 5);
      bus.enable = 1'b1;
      step(3);
      bus.enable = 1'b0;
      step(2);

      // Reset mid-count in WARN at remain=7, then rearm.
      set_cfg(10, 8);
      bus.enable = 1'b1;
      step(1);
      ticks(3, 2);
      rst = 1'b1;
      step(2);
      ticks(10, 2);
      step(2);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(49) == 0) bus.enable = ~bus.enable;
         if ($urandom_range(19) == 0) bus.timeout = W'($urandom_range(12));
         if ($urandom_range(19) == 0) bus.warn_lvl = W'($urandom_range(8));
         bus.tick_1ms = ($urandom_range(3) == 0);
         bus.kick     = ($urandom_range(15) == 0);
         bus.clr      = ($urandom_range(11) == 0);
         rst          = ($urandom_range(499) == 0);
         step(1);
      end
      step(2);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/tick_watchdog.md
# tick_watchdog

Millisecond watchdog timer that consumes the single-cycle 1 ms tick strobe from the system timebase and counts down a programmable timeout. Software or a supervising FSM must kick it before expiry. It raises a warning window before expiry, a one-cycle expiry pulse, and a sticky expired flag. It sits beside the timebase in the system-control block and feeds the reset/interrupt controller.

## Interface
- CNT_W, 16, width of timeout, warning level and remaining-count fields (ms units)
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- tick_1ms  in  1  one-clk strobe per millisecond, already synchronous to clk
- enable  in  1  level; arms the watchdog
- timeout  in  CNT_W  reload value in ms; sampled on arm, kick and clear
- warn_lvl  in  CNT_W  remaining count at or below which WARN is entered; 0 disables warning
- kick  in  1  one-clk strobe; reloads the counter
- clr  in  1  one-clk strobe; clears the expired state
- state  out  2  00 IDLE, 01 RUN, 10 WARN, 11 EXPIRED
- remain  out  CNT_W  ms remaining
- warn  out  1  high while state==WARN
- expire_pulse  out  1  one-clk pulse on entry to EXPIRED
- expired  out  1  high while state==EXPIRED
- kick_err  out  1  one-clk pulse when kick arrives in EXPIRED or IDLE

## Operation
- All outputs are registered. Reset value of every output is 0, with state IDLE.
- The effective load value L is timeout if timeout is nonzero, else 1. A timeout of 0 never expires instantly.
- Next-state rule for a loaded or decremented value r in RUN/WARN:
  - r==0: EXPIRED.
  - warn_lvl!=0 and r<=warn_lvl: WARN.
  - Otherwise: RUN.
- IDLE:
  - remain=0.
  - enable=1 loads remain=L, then applies the next-state rule.
  - kick gives kick_err and is otherwise ignored.
- RUN/WARN:
  - Per-cycle priority: enable=0 > kick > tick_1ms.
  - enable=0: go to IDLE, remain=0.
  - kick: remain=L, apply the next-state rule. A tick in the same cycle is discarded.
  - tick_1ms with no kick: remain=remain-1, apply the next-state rule.
  - Going from 1 to 0 enters EXPIRED and asserts expire_pulse.
  - Decrement never wraps, because the counter never decrements from 0.
- EXPIRED:
  - Sticky. remain holds 0. Ticks are ignored.
  - enable=0 does not leave EXPIRED.
  - kick gives kick_err only.
  - clr with enable=1: remain=L, apply the next-state rule.
  - clr with enable=0: go to IDLE.
- clr outside EXPIRED has no effect.
- rst is honoured in any state, mid-count included, and returns to the reset values next cycle.

## Timing
- Every input is sampled at posedge N; the response is visible after posedge N+1 (one-cycle latency).
- Arm: enable rises at N, so remain=L and state RUN/WARN from N+1.
- Expiry: a tick at N with remain==1 gives state=EXPIRED, remain=0 and expire_pulse=1 from N+1. expire_pulse is low at N+2.
- Pulse widths:
  - expire_pulse and kick_err are exactly one clk wide.
  - Back-to-back kicks give back-to-back kick_err pulses.
- Time to expiry after arm or kick: exactly L ticks. The L-th tick after the load edge expires the counter.
- Changes to timeout or warn_lvl take effect at the next load. warn_lvl is also compared on every decrement.

## Test plan
- Arm and expire:
  - Stimulus: timeout=5, warn_lvl=0, enable=1, then 5 ticks spaced 10 clk.
  - Required: remain steps 5,4,3,2,1,0. The 5th tick gives expire_pulse for 1 clk, then expired=1 and state=11 held for 100 clk of further ticks.
- Warning window and kick recovery:
  - Stimulus: timeout=10, warn_lvl=3, run 7 ticks, then kick.
  - Required: warn=1 when remain=3. After the kick, remain=10, state=RUN, warn=0. Expiry occurs only 10 ticks after the kick.
- Kick and tick in the same cycle:
  - Stimulus: timeout=4, remain=1, kick and tick_1ms asserted together.
  - Required: remain=4 and no expire_pulse.
- Sticky expiry, clr and kick_err:
  - Stimulus: in EXPIRED, send kick, then drop enable, then clr.
  - Required: kick gives a kick_err 1-clk pulse. With enable=0, state stays 11. clr returns state to 00. clr with enable=1 instead reloads to RUN with remain=timeout.
- Boundary loads:
  - Stimulus: arm with timeout=0.
  - Required: remain=1, and one tick expires it.
  - Stimulus: arm with timeout=3 and warn_lvl=5.
  - Required: state=WARN immediately on arm.
- Reset mid-count:
  - Stimulus: assert rst for 1 clk while remain=7 in WARN.
  - Required: next cycle all outputs are 0, with state IDLE.
  - Stimulus: arm afterwards.
  - Required: normal behaviour.
